sdram_rw_sched: RTL and testbench
=================================

# sdram_rw_sched

Burst scheduler in front of the SDRAM write and read engines. It decides when a write burst or a read burst runs, and fires the matching trigger. It generates the bank/row/column for every burst and rotates whole frames across three SDRAM banks (triple buffering), so the display side never reads a frame that is still being written. It sits between the write/read FIFOs' level signals and the `sdram_top` write/read engines, and replaces free-running trigger generation.

## Interface
Parameters:
- `BURST_LEN`, 8: words per burst. Power of two, ≤ 2^`COL_W`.
- `COL_W`, 9: column address width.
- `ROW_W`, 13: row address width.
- `FB_W`, 16: frame burst counter width.
- `FRAME_BURSTS`, 38400: bursts per frame. Range 1..2^`FB_W`−1.
- `LVL_W`, 11: FIFO level width.
- `RFIFO_DEPTH`, 1024: read FIFO capacity in words.

Ports:
- `clk` in 1: system/SDRAM controller clock.
- `rst` in 1: reset, asynchronous and active-high.
- `init_done` in 1: SDRAM initialisation complete, level.
- `wfifo_level` in `LVL_W`: words held in the write FIFO, `clk` domain.
- `rfifo_level` in `LVL_W`: words held in the read FIFO, `clk` domain.
- `wr_done` in 1: one-cycle pulse, write burst finished.
- `rd_done` in 1: one-cycle pulse, read burst finished.
- `wr_trig` out 1: one-cycle pulse, start a write burst.
- `rd_trig` out 1: one-cycle pulse, start a read burst.
- `wr_bank` out 2, `wr_row` out `ROW_W`, `wr_col` out `COL_W`: current write burst address.
- `rd_bank` out 2, `rd_row` out `ROW_W`, `rd_col` out `COL_W`: current read burst address.
- `frame_wr_done` out 1: pulse, last write burst of a frame completed.
- `frame_rd_done` out 1: pulse, last read burst of a frame completed.
- `sched_state` out 2: current FSM state, for debug.

## Operation
- FSM states and encodings:
  - IDLE=0: leave to ARB when `init_done`=1.
  - ARB=1: arbitration.
  - WR_WAIT=2: return to ARB on `wr_done`.
  - RD_WAIT=3: return to ARB on `rd_done`.
- Request conditions, evaluated in ARB:
  - `wr_ok` = `wfifo_level` ≥ `BURST_LEN`.
  - `rd_ok` = (`RFIFO_DEPTH` − `rfifo_level`) ≥ `BURST_LEN`, and a frame is available (`rd_valid` or `new_frame`).
- Arbitration:
  - Only one requester ready: grant it.
  - Both ready: round-robin. `last_grant` flag, reset = read, so the first tie grants write.
  - Neither ready: stay in ARB.
- Grant: the trigger pulses and the FSM enters the matching WAIT state.
- Burst completion (done pulse in WAIT):
  - col += `BURST_LEN`.
  - If col wraps to 0, row += 1.
  - Burst counter += 1.
  - At `FRAME_BURSTS`: row, col and counter go to 0, and the frame-done pulse fires.
- Write frame end:
  - `last_done` <= `wr_bank`; `new_frame` <= 1.
  - `wr_bank` <= lowest bank in {0,1,2} that is ≠ `last_done` (new value) and ≠ `rd_bank` when `rd_valid`.
  - Bank 3 is never used.
- Read frame start (grant with read burst counter = 0 and `new_frame`=1):
  - `rd_bank` <= `last_done`; `rd_valid` <= 1; `new_frame` <= 0.
  - With `new_frame`=0 the same bank is re-read (frame repeat).
- `wr_done` and `rd_done` cannot coincide, because bursts are serialised. A done pulse outside its WAIT state is ignored.
- Refresh is internal to the engines; the scheduler just waits for done. The WAIT states have no timeout.
- Reset values:
  - State IDLE; all address outputs 0; all pulses 0.
  - `last_done`=0, `new_frame`=0, `rd_valid`=0, `last_grant`=read.
- Reset mid-burst returns everything to the reset values immediately. Any in-flight engine burst is the engines' concern.
- `init_done` is used only in IDLE. It is not re-checked afterwards.

## Timing
- `wr_trig`/`rd_trig` are registered, high exactly one cycle: the first cycle in WR_WAIT/RD_WAIT.
- ARB to trigger latency: 1 clock edge after the conditions are sampled true.
- Address outputs are registered and stable from the trigger cycle until the edge that samples done.
- The address update and the FSM return to ARB happen on the same edge that samples done.
- The frame-done pulse is high in the cycle after that edge.
- ARB lasts at least 1 cycle, so back-to-back triggers are ≥ 2 cycles apart after done.
- `rd_bank` latch at read frame start takes effect on the trigger cycle, so the trigger carries the new bank.
- Level inputs are used as sampled. The FIFOs guarantee the levels are pessimistic (synchronised pointers).

## Test plan
- Init gating: hold `init_done`=0 with `wfifo_level`=100 → no `wr_trig`, `sched_state`=0. Raise `init_done` → `wr_trig` at bank0/row0/col0 within 2 cycles.
- Address walk (`COL_W`=4, `BURST_LEN`=8): 3 write bursts → col 0, 8, 0 and row 0, 0, 1.
- Triple-buffer rotation (`FRAME_BURSTS`=4, both sides always ready):
  - Write frames use banks 0, 1, then 2 or 0 depending on `rd_bank`.
  - `rd_bank` is never equal to `wr_bank` during a burst.
  - Bank 3 is never used.
- Tie fairness: `wfifo_level`=64, `rfifo_level`=0, frame available → triggers alternate W, R, W, R.
- Back-pressure: `rfifo_level`=1020 (`RFIFO_DEPTH`=1024) → no `rd_trig`. Writes still issue when `wfifo_level` ≥ 8.
- Reset mid-burst: assert `rst` in WR_WAIT → all outputs 0 in the same cycle. After release, no trigger until `init_done`. A stray `wr_done` in ARB causes no address change.

Source files
------------

// File: rtl/sdram_rw_sched.sv
// -----------------------------------------------------------------------------
// sdram_rw_sched
//
// Burst scheduler between the write/read FIFO level signals and the SDRAM
// write/read engines. It decides which burst runs next, fires a one-cycle
// trigger, and generates the bank/row/column address for each burst. Whole
// frames rotate across banks 0..2 (triple buffering), so the reader never
// scans a bank that the writer is filling. Bank 3 is never used.
//
// Handshake: a trigger (wr_trig/rd_trig) is a registered one-cycle pulse in
// the first cycle of the matching WAIT state, and the address outputs are
// stable from that cycle until the edge that samples the engine's done pulse.
// Each done is accepted only in its own WAIT state. No new trigger is issued
// until the outstanding burst reports done.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   init_done              SDRAM init complete (used only in IDLE)
//   wfifo_level            words in write FIFO
//   rfifo_level            words in read FIFO
//   wr_done / rd_done      burst-finished pulses from the engines
//   wr_trig / rd_trig      burst-start pulses to the engines
//   wr_bank/row/col        write burst address
//   rd_bank/row/col        read burst address
//   frame_wr_done          pulse after the last write burst of a frame
//   frame_rd_done          pulse after the last read burst of a frame
//   sched_state            FSM state (debug)
// -----------------------------------------------------------------------------
module sdram_rw_sched #(
  parameter int BURST_LEN    = 8,
  parameter int COL_W        = 9,
  parameter int ROW_W        = 13,
  parameter int FB_W         = 16,
  parameter int FRAME_BURSTS = 38400,
  parameter int LVL_W        = 11,
  parameter int RFIFO_DEPTH  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_done,
  input  logic [LVL_W-1:0] wfifo_level,
  input  logic [LVL_W-1:0] rfifo_level,
  input  logic             wr_done,
  input  logic             rd_done,
  output logic             wr_trig,
  output logic             rd_trig,
  output logic [1:0]       wr_bank,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [1:0]       rd_bank,
  output logic [ROW_W-1:0] rd_row,
  output logic [COL_W-1:0] rd_col,
  output logic             frame_wr_done,
  output logic             frame_rd_done,
  output logic [1:0]       sched_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARB     = 2'd1;
  localparam logic [1:0] S_WR_WAIT = 2'd2;
  localparam logic [1:0] S_RD_WAIT = 2'd3;

  // When BURST_LEN equals 2^COL_W the step truncates to 0, so the column
  // stays 0 and every burst advances the row, which is the intended walk.
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(BURST_LEN);
  localparam logic [FB_W-1:0]  FB_LAST  = FB_W'(FRAME_BURSTS - 1);

  logic [1:0]      state;
  logic [FB_W-1:0] wr_cnt;
  logic [FB_W-1:0] rd_cnt;
  logic [1:0]      last_done;   // bank of the most recently completed frame
  logic            new_frame;   // a completed frame not yet picked by reader
  logic            rd_valid;    // rd_bank holds a real frame
  logic            last_grant;  // 1 = read was granted last

  logic            wr_ok;
  logic            rd_ok;
  logic            grant_wr;
  logic            grant_rd;
  logic [COL_W-1:0] wr_col_nxt;
  logic [COL_W-1:0] rd_col_nxt;
  logic [1:0]      wr_bank_nxt;

  // Lowest bank in 0..2 that is neither the frame just completed nor the
  // bank the reader is scanning.
  function automatic logic [1:0] pick_bank(input logic [1:0] done_bank,
                                           input logic [1:0] busy_bank,
                                           input logic       busy_valid);
    logic [1:0] b;
    if (done_bank != 2'd0 && !(busy_valid && busy_bank == 2'd0))
      b = 2'd0;
    else if (done_bank != 2'd1 && !(busy_valid && busy_bank == 2'd1))
      b = 2'd1;
    else
      b = 2'd2;
    return b;
  endfunction

  always_comb begin
    wr_ok = 32'(wfifo_level) >= 32'(BURST_LEN);
    // Free space computed as level + burst <= depth to avoid underflow.
    rd_ok = ((32'(rfifo_level) + 32'(BURST_LEN)) <= 32'(RFIFO_DEPTH))
            && (rd_valid || new_frame);
    // Tie: grant the side that did not win last time.
    grant_wr = wr_ok && (!rd_ok || last_grant);
    grant_rd = rd_ok && (!wr_ok || !last_grant);
    wr_col_nxt  = wr_col + COL_STEP;
    rd_col_nxt  = rd_col + COL_STEP;
    wr_bank_nxt = pick_bank(wr_bank, rd_bank, rd_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wr_trig       <= 1'b0;
      rd_trig       <= 1'b0;
      wr_bank       <= 2'd0;
      wr_row        <= '0;
      wr_col        <= '0;
      rd_bank       <= 2'd0;
      rd_row        <= '0;
      rd_col        <= '0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      frame_wr_done <= 1'b0;
      frame_rd_done <= 1'b0;
      last_done     <= 2'd0;
      new_frame     <= 1'b0;
      rd_valid      <= 1'b0;
      last_grant    <= 1'b1;
    end else begin
      wr_trig       <= 1'b0;
      rd_trig       <= 1'b0;
      frame_wr_done <= 1'b0;
      frame_rd_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (init_done) state <= S_ARB;
        end

        S_ARB: begin
          if (grant_wr) begin
            state      <= S_WR_WAIT;
            wr_trig    <= 1'b1;
            last_grant <= 1'b0;
          end else if (grant_rd) begin
            state      <= S_RD_WAIT;
            rd_trig    <= 1'b1;
            last_grant <= 1'b1;
            // Start of a read frame: switch to the newest completed frame if
            // there is one, otherwise keep re-reading the current bank.
            if (rd_cnt == '0 && new_frame) begin
              rd_bank   <= last_done;
              rd_valid  <= 1'b1;
              new_frame <= 1'b0;
            end
          end
        end

        S_WR_WAIT: begin
          if (wr_done) begin
            state <= S_ARB;
            if (wr_cnt == FB_LAST) begin
              wr_cnt        <= '0;
              wr_row        <= '0;
              wr_col        <= '0;
              frame_wr_done <= 1'b1;
              last_done     <= wr_bank;
              new_frame     <= 1'b1;
              wr_bank       <= wr_bank_nxt;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
              wr_col <= wr_col_nxt;
              if (wr_col_nxt == '0) wr_row <= wr_row + 1'b1;
            end
          end
        end

        default: begin  // S_RD_WAIT
          if (rd_done) begin
            state <= S_ARB;
            if (rd_cnt == FB_LAST) begin
              rd_cnt        <= '0;
              rd_row        <= '0;
              rd_col        <= '0;
              frame_rd_done <= 1'b1;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
              rd_col <= rd_col_nxt;
              if (rd_col_nxt == '0) rd_row <= rd_row + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign sched_state = state;

endmodule

// File: tb/tb_sdram_rw_sched.sv
// -----------------------------------------------------------------------------
// tb_sdram_rw_sched
//
// Directed bench for sdram_rw_sched with a small geometry (COL_W=4,
// BURST_LEN=8, FRAME_BURSTS=4). A table of {levels, expected trigger, expected
// address, expected frame-done} records drives the main walk: address
// stepping, triple-buffer rotation, tie alternation, back-pressure and frame
// repeat. Hand-written sequences cover reset, init gating, reset mid-burst and
// a stray done in ARB.
// -----------------------------------------------------------------------------
module tb_sdram_rw_sched;

  localparam int BURST_LEN    = 8;
  localparam int COL_W        = 4;
  localparam int ROW_W        = 13;
  localparam int FB_W         = 16;
  localparam int FRAME_BURSTS = 4;
  localparam int LVL_W        = 11;
  localparam int RFIFO_DEPTH  = 1024;
  localparam int NVEC         = 27;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             init_done = 1'b0;
  logic [LVL_W-1:0] wfifo_level = '0;
  logic [LVL_W-1:0] rfifo_level = '0;
  logic             wr_done = 1'b0;
  logic             rd_done = 1'b0;
  logic             wr_trig;
  logic             rd_trig;
  logic [1:0]       wr_bank;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [1:0]       rd_bank;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic             frame_wr_done;
  logic             frame_rd_done;
  logic [1:0]       sched_state;

  sdram_rw_sched #(
    .BURST_LEN(BURST_LEN), .COL_W(COL_W), .ROW_W(ROW_W), .FB_W(FB_W),
    .FRAME_BURSTS(FRAME_BURSTS), .LVL_W(LVL_W), .RFIFO_DEPTH(RFIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wfifo_level(wfifo_level), .rfifo_level(rfifo_level),
    .wr_done(wr_done), .rd_done(rd_done),
    .wr_trig(wr_trig), .rd_trig(rd_trig),
    .wr_bank(wr_bank), .wr_row(wr_row), .wr_col(wr_col),
    .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col),
    .frame_wr_done(frame_wr_done), .frame_rd_done(frame_rd_done),
    .sched_state(sched_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_addr(input int bank, input int row,
                                            input int col);
    return {13'd0, 2'(bank), 13'(row), 4'(col)};
  endfunction

  // ---------------- driver tasks ----------------
  // kind: 0 = no trigger within budget, 1 = write, 2 = read
  task automatic wait_trig(input int budget, output int kind);
    int n;
    kind = 0;
    n = 0;
    while (kind == 0 && n < budget) begin
      @(negedge clk);
      if (wr_trig) kind = 1;
      else if (rd_trig) kind = 2;
      n++;
    end
  endtask

  task automatic pulse_done(input int kind);
    if (kind == 1) wr_done = 1'b1;
    else           rd_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    rd_done = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int wlvl;
    int rlvl;
    int kind;    // expected trigger
    int bank;
    int row;
    int col;
    int fdone;   // expected frame-done after this burst's done
  } vec_t;

  vec_t vecs[NVEC];

  initial begin
    int kind;
    int budget;
    bit rd_seen;
    logic [31:0] act_addr;
    logic [31:0] exp_fd;

    // write-only first frame: column walk 0,8 then row step
    vecs[0]  = '{100, 1024, 1, 0, 0, 0, 0};
    vecs[1]  = '{100, 1024, 1, 0, 0, 8, 0};
    vecs[2]  = '{100, 1024, 1, 0, 1, 0, 0};
    vecs[3]  = '{100, 1024, 1, 0, 1, 8, 1};
    // both ready: alternate, starting with read since write won last
    vecs[4]  = '{64, 0, 2, 0, 0, 0, 0};
    vecs[5]  = '{64, 0, 1, 1, 0, 0, 0};
    vecs[6]  = '{64, 0, 2, 0, 0, 8, 0};
    vecs[7]  = '{64, 0, 1, 1, 0, 8, 0};
    vecs[8]  = '{64, 0, 2, 0, 1, 0, 0};
    vecs[9]  = '{64, 0, 1, 1, 1, 0, 0};
    vecs[10] = '{64, 0, 2, 0, 1, 8, 1};
    vecs[11] = '{64, 0, 1, 1, 1, 8, 1};
    vecs[12] = '{64, 0, 2, 1, 0, 0, 0};
    vecs[13] = '{64, 0, 1, 2, 0, 0, 0};
    // read FIFO nearly full: writes only; next write frame goes to bank 0
    vecs[14] = '{100, 1020, 1, 2, 0, 8, 0};
    vecs[15] = '{100, 1020, 1, 2, 1, 0, 0};
    vecs[16] = '{100, 1020, 1, 2, 1, 8, 1};
    vecs[17] = '{7, 1020, 0, 0, 0, 0, 0};
    // exactly one burst of space, write FIFO one short of a burst
    vecs[18] = '{7, 1016, 2, 1, 0, 8, 0};
    vecs[19] = '{7, 1016, 2, 1, 1, 0, 0};
    vecs[20] = '{7, 1016, 2, 1, 1, 8, 1};
    vecs[21] = '{7, 1016, 2, 2, 0, 0, 0};
    vecs[22] = '{7, 1016, 2, 2, 0, 8, 0};
    vecs[23] = '{7, 1016, 2, 2, 1, 0, 0};
    vecs[24] = '{7, 1016, 2, 2, 1, 8, 1};
    vecs[25] = '{7, 1016, 2, 2, 0, 0, 0};  // no new frame: repeat bank 2
    vecs[26] = '{8, 1020, 1, 0, 0, 0, 0};

    // ---------------- reset ----------------
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(sched_state), 0);
    check("reset_trigs", {30'd0, wr_trig, rd_trig}, 0);
    check("reset_wr_addr", pack_addr(wr_bank, wr_row, wr_col), 0);
    check("reset_rd_addr", pack_addr(rd_bank, rd_row, rd_col), 0);
    check("reset_frame_pulses", {30'd0, frame_wr_done, frame_rd_done}, 0);

    // ---------------- init gating ----------------
    wfifo_level = 100;
    rfifo_level = 1024;
    rst = 1'b0;
    wait_trig(8, kind);
    check("init_gate_no_trig", 32'(kind), 0);
    check("init_gate_state", 32'(sched_state), 0);
    init_done = 1'b1;

    // ---------------- table walk ----------------
    rd_seen = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      wfifo_level = LVL_W'(vecs[i].wlvl);
      rfifo_level = LVL_W'(vecs[i].rlvl);
      budget = (i == 0) ? 2 : ((vecs[i].kind == 0) ? 6 : 4);
      wait_trig(budget, kind);
      check($sformatf("v%0d_trig_kind", i), 32'(kind), 32'(vecs[i].kind));
      if (kind == 0) begin
        check($sformatf("v%0d_state_arb", i), 32'(sched_state), 1);
      end else begin
        if (kind == 2) rd_seen = 1'b1;
        exp_q.push_back(pack_addr(vecs[i].bank, vecs[i].row, vecs[i].col));
        act_addr = (kind == 1) ? pack_addr(wr_bank, wr_row, wr_col)
                               : pack_addr(rd_bank, rd_row, rd_col);
        check($sformatf("v%0d_addr", i), act_addr, exp_q.pop_front());
        check($sformatf("v%0d_state_wait", i), 32'(sched_state),
              (kind == 1) ? 32'd2 : 32'd3);
        check($sformatf("v%0d_wr_bank_not3", i), 32'(wr_bank == 2'd3), 0);
        check($sformatf("v%0d_rd_bank_not3", i), 32'(rd_bank == 2'd3), 0);
        if (rd_seen)
          check($sformatf("v%0d_banks_differ", i), 32'(wr_bank == rd_bank), 0);
        // one cycle later: pulse gone, address held
        @(negedge clk);
        check($sformatf("v%0d_trig_one_cycle", i),
              {30'd0, wr_trig, rd_trig}, 0);
        check($sformatf("v%0d_addr_stable", i),
              (kind == 1) ? pack_addr(wr_bank, wr_row, wr_col)
                          : pack_addr(rd_bank, rd_row, rd_col), act_addr);
        pulse_done(kind);
        exp_fd = (vecs[i].kind == 1) ? {30'd0, 1'(vecs[i].fdone), 1'b0}
                                     : {30'd0, 1'b0, 1'(vecs[i].fdone)};
        check($sformatf("v%0d_frame_done", i),
              {30'd0, frame_wr_done, frame_rd_done}, exp_fd);
        check($sformatf("v%0d_back_to_arb", i), 32'(sched_state), 1);
      end
    end

    // ---------------- reset mid-burst ----------------
    wfifo_level = 100;
    rfifo_level = 1024;
    wait_trig(4, kind);
    check("midrst_trig_kind", 32'(kind), 1);
    check("midrst_addr_before", pack_addr(wr_bank, wr_row, wr_col),
          pack_addr(0, 0, 8));
    rst = 1'b1;
    init_done = 1'b0;
    #1;
    check("midrst_state", 32'(sched_state), 0);
    check("midrst_trigs", {30'd0, wr_trig, rd_trig}, 0);
    check("midrst_wr_addr", pack_addr(wr_bank, wr_row, wr_col), 0);
    check("midrst_rd_addr", pack_addr(rd_bank, rd_row, rd_col), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_trig(6, kind);
    check("post_rst_no_trig", 32'(kind), 0);
    check("post_rst_idle", 32'(sched_state), 0);

    // ---------------- stray done in ARB ----------------
    wfifo_level = 0;
    init_done = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_in_arb", 32'(sched_state), 1);
    pulse_done(1);
    pulse_done(2);
    check("stray_wr_addr", pack_addr(wr_bank, wr_row, wr_col), 0);
    check("stray_rd_addr", pack_addr(rd_bank, rd_row, rd_col), 0);
    check("stray_frame_pulses", {30'd0, frame_wr_done, frame_rd_done}, 0);
    check("stray_state", 32'(sched_state), 1);
    wfifo_level = 100;
    wait_trig(4, kind);
    check("after_stray_kind", 32'(kind), 1);
    check("after_stray_addr", pack_addr(wr_bank, wr_row, wr_col), 0);
    if (kind != 0) begin
      @(negedge clk);
      pulse_done(kind);
      check("after_stray_step", pack_addr(wr_bank, wr_row, wr_col),
            pack_addr(0, 0, 8));
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
